serial_comparator_ctrl: RTL and testbench

SERIAL_COMPARATOR_CTRL -- requirements
Module: serial_comparator_ctrl

---
 rtl/serial_comparator_ctrl.sv | 109 ++++++++++
 tb/tb_serial_comparator_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/serial_comparator_ctrl.sv
// Bit-serial MSB-first magnitude comparator. It examines one bit pair per cycle
// and stops at the first difference, so bits_used shows how far the scan went.
module serial_comparator_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [WIDTH-1:0]           a_in,
   input  logic [WIDTH-1:0]           b_in,
   output logic                       busy,
   output logic                       done,
   output logic                       smaller,
   output logic                       equal,
   output logic                       greater,
   output logic [$clog2(WIDTH+1)-1:0] bits_used
);

   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int CW = $clog2(WIDTH+1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] sh_a, sh_b;
   logic [IW-1:0]    idx;
   logic [CW-1:0]    cnt;
   logic             load;
   logic             bit_a, bit_b;
   logic             differ, last;
   logic             finish;

   // Current bit pair under test. It is only meaningful while in RUN.
   assign bit_a  = sh_a[idx];
   assign bit_b  = sh_b[idx];
   assign differ = bit_a ^ bit_b;
   assign last   = (idx == '0);

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      finish    = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (differ || last) begin
               finish    = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               load      = 1'b1;
               state_nxt = RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         sh_a      <= '0;
         sh_b      <= '0;
         idx       <= '0;
         cnt       <= '0;
         smaller   <= 1'b0;
         equal     <= 1'b0;
         greater   <= 1'b0;
         bits_used <= '0;
      end else begin
         state <= state_nxt;
         if (load) begin
            sh_a <= a_in;
            sh_b <= b_in;
            idx  <= IW'(WIDTH-1);
            cnt  <= '0;
         end else if (state == RUN) begin
            cnt <= cnt + CW'(1);
            if (!finish)
               idx <= idx - IW'(1);
         end
         // The result is registered on DONE entry and held until the next one.
         if (finish) begin
            greater   <= differ & bit_a;
            smaller   <= differ & bit_b;
            equal     <= ~differ;
            bits_used <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_serial_comparator_ctrl.sv
// Directed test of serial_comparator_ctrl at WIDTH=8, using hand-computed
// latencies and results.
module tb_serial_comparator_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] a_in = '0;
   logic [7:0] b_in = '0;
   logic       busy, done, smaller, equal, greater;
   logic [3:0] bits_used;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int bc       = 0;
   int dcnt     = 0;

   serial_comparator_ctrl #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
      .busy(busy), .done(done), .smaller(smaller), .equal(equal),
      .greater(greater), .bits_used(bits_used)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_res(input string tag, input logic s, input logic e, input logic g,
                          input logic [3:0] bu);
      chk({tag, "_res"}, 32'({smaller, equal, greater}), 32'({s, e, g}));
      chk({tag, "_bits"}, 32'(bits_used), 32'(bu));
   endtask

   // Drive start for one cycle and leave the bench in cycle 1.
   task automatic issue(input logic [7:0] a, input logic [7:0] b);
      a_in  = a;
      b_in  = b;
      start = 1'b1;
      tick();
      start = 1'b0;
      cyc   = 1;
      bc    = 0;
   endtask

   // Stop in the cycle where done is high, with a bounded wait.
   task automatic wait_done();
      while (!done && cyc < 40) begin
         if (busy) bc++;
         tick();
         cyc++;
      end
   endtask

   initial begin
      // Reset, with a start that must be ignored.
      start = 1'b1;
      a_in  = 8'h01;
      tick();
      tick();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk_res("rst", 0, 0, 0, 4'd0);
      rst   = 1'b0;
      start = 1'b0;
      tick();
      chk("rst_start_dropped", 32'(busy), 0);

      // Equal operands cover all eight bits.
      issue(8'hA5, 8'hA5);
      wait_done();
      chk("eq_lat", cyc, 9);
      chk("eq_busy_cycles", bc, 8);
      chk("eq_done_busy", 32'(busy), 0);
      chk_res("eq", 0, 1, 0, 4'd8);
      tick();
      chk("eq_done_pulse", 32'(done), 0);
      chk("eq_idle", 32'(busy), 0);

      // The MSB differs, so the compare ends after one bit.
      issue(8'h80, 8'h7F);
      wait_done();
      chk("msb_lat", cyc, 2);
      chk_res("msb", 0, 0, 1, 4'd1);
      tick();

      // LSB differs, followed by a back-to-back start in the DONE cycle.
      issue(8'h12, 8'h13);
      wait_done();
      chk("lsb_lat", cyc, 9);
      chk_res("lsb", 1, 0, 0, 4'd8);
      a_in  = 8'h00;
      b_in  = 8'h01;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("b2b_no_idle", 32'(busy), 1);
      chk_res("b2b_hold", 1, 0, 0, 4'd8);
      cyc = 1;
      bc  = 0;
      wait_done();
      chk("b2b_busy_cycles", bc, 8);
      chk_res("b2b", 1, 0, 0, 4'd8);
      tick();

      // A start during RUN and operand changes must be ignored.
      issue(8'h40, 8'h00);
      a_in  = 8'h00;
      b_in  = 8'hFF;
      start = 1'b1;
      tick();
      start = 1'b0;
      a_in  = 8'h55;
      b_in  = 8'hAA;
      cyc   = 2;
      wait_done();
      chk("ign_lat", cyc, 3);
      chk_res("ign", 0, 0, 1, 4'd2);
      tick();
      chk("ign_back_idle", 32'(busy | done), 0);
      // The result holds while idle and while inputs move.
      a_in = 8'hFF;
      tick();
      tick();
      chk_res("hold", 0, 0, 1, 4'd2);

      // Reset in the middle of RUN discards the compare.
      issue(8'h0F, 8'h0E);
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_done", 32'(done), 0);
      chk_res("mid_rst", 0, 0, 0, 4'd0);
      rst  = 1'b0;
      dcnt = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (done) dcnt++;
      end
      chk("mid_rst_no_done", dcnt, 0);

      // Normal operation after reset.
      issue(8'h03, 8'h05);
      wait_done();
      chk("post_rst_lat", cyc, 7);
      chk_res("post_rst", 1, 0, 0, 4'd6);
      tick();

      // Extreme operand values.
      issue(8'h00, 8'hFF);
      wait_done();
      chk("ext0_lat", cyc, 2);
      chk_res("ext0", 1, 0, 0, 4'd1);
      tick();
      issue(8'hFF, 8'hFE);
      wait_done();
      chk("ext1_lat", cyc, 9);
      chk_res("ext1", 0, 0, 1, 4'd8);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
